// File: rtl/scipio_pkg.sv
// ---------------------------------------------------------------------------
// scipio_pkg
// Shared types and constants for the ID->EX dispatch interface.
//   rs_entry_t : one reservation-station slot (valid, opcode, two producer
//                tags, two operand values, destination ROB slot)
//   TAG_NONE   : tag value meaning "no producer, operand value present"
//   EXU_*      : functional-unit codes carried on the dispatch bus
// The entry record is sized by the RS_* widths below; stations built from
// it must use matching OP_W / TAG_W / VAL_W.
// ---------------------------------------------------------------------------
package scipio_pkg;

    localparam int RS_OP_W  = 8;
    localparam int RS_TAG_W = 5;
    localparam int RS_VAL_W = 32;

    localparam logic [RS_TAG_W-1:0] TAG_NONE = '0;

    localparam logic [2:0] EXU_ALU = 3'd0;
    localparam logic [2:0] EXU_MUL = 3'd1;
    localparam logic [2:0] EXU_LSU = 3'd2;
    localparam logic [2:0] EXU_BRU = 3'd3;

    typedef struct packed {
        logic                          valid;
        logic [RS_OP_W-1:0]            op;
        logic [1:2][RS_TAG_W-1:0]      tag;
        logic [1:2][RS_VAL_W-1:0]      val;
        logic [RS_TAG_W-1:0]           target;
    } rs_entry_t;

    // An entry may issue once both operand values have been captured.
    function automatic logic rs_is_ready(input rs_entry_t e);
        return e.valid && (e.tag[1] == TAG_NONE) && (e.tag[2] == TAG_NONE);
    endfunction

endpackage

// File: rtl/rs_select.sv
// ---------------------------------------------------------------------------
// rs_select
// Lowest-index priority pick over a request vector (index 0 = oldest).
//   i_req    : DEPTH-wide ready vector
//   o_onehot : one-hot of the lowest set request bit (all zero if none)
//   o_idx    : binary index of the same bit (zero if none)
//   o_any    : at least one request bit set
// ---------------------------------------------------------------------------
module rs_select #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0]         i_req,
    output logic [DEPTH-1:0]         o_onehot,
    output logic [$clog2(DEPTH)-1:0] o_idx,
    output logic                     o_any
);

    localparam int IDX_W = $clog2(DEPTH);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_onehot    = '0;
                o_onehot[i] = 1'b1;
                o_idx       = IDX_W'(i);
                o_any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_rs.sv
// ---------------------------------------------------------------------------
// ex_rs
// Reservation station for one functional unit. Holds dispatched instructions
// in a collapsing queue (entry 0 oldest) until both operands have arrived on
// the common data bus, then issues them oldest-ready-first.
//   clk, rst (async, active-low), flush (sync squash of all entries)
//   in_valid/in_ready, in_ex_unit, in_op, in_tag1/2, in_val1/2, in_target
//                      : dispatch port; only in_ex_unit == UNIT_ID is taken
//   cdb_valid, cdb_tag, cdb_val : result broadcast (cdb_tag never TAG_NONE)
//   iss_valid/iss_ready, iss_op, iss_val1/2, iss_target : issue handshake
//   count              : number of occupied entries
// ---------------------------------------------------------------------------
module ex_rs
    import scipio_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [2:0] UNIT_ID = EXU_ALU,
    parameter int         OP_W    = RS_OP_W,
    parameter int         TAG_W   = RS_TAG_W,
    parameter int         VAL_W   = RS_VAL_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_ex_unit,
    input  logic [OP_W-1:0]            in_op,
    input  logic [TAG_W-1:0]           in_tag1,
    input  logic [TAG_W-1:0]           in_tag2,
    input  logic [VAL_W-1:0]           in_val1,
    input  logic [VAL_W-1:0]           in_val2,
    input  logic [TAG_W-1:0]           in_target,
    input  logic                       cdb_valid,
    input  logic [TAG_W-1:0]           cdb_tag,
    input  logic [VAL_W-1:0]           cdb_val,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [OP_W-1:0]            iss_op,
    output logic [VAL_W-1:0]           iss_val1,
    output logic [VAL_W-1:0]           iss_val2,
    output logic [TAG_W-1:0]           iss_target,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    rs_entry_t        r_ent [DEPTH];
    logic [CNT_W-1:0] r_count;

    rs_entry_t        w_ext  [DEPTH+1];
    rs_entry_t        w_next [DEPTH];
    rs_entry_t        w_new_raw;
    rs_entry_t        w_new;
    logic [DEPTH-1:0] w_ready;
    logic [DEPTH-1:0] w_sel_onehot;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_any;
    logic             w_issue;
    logic             w_accept;
    logic [CNT_W-1:0] w_wr_pos;

    // CDB capture: any still-pending operand whose tag matches the broadcast
    // takes the value and becomes present. Used for held entries and for the
    // incoming entry, so a result broadcast in the dispatch cycle is not lost.
    function automatic rs_entry_t cdb_capture(
        input rs_entry_t        e,
        input logic             bvalid,
        input logic [TAG_W-1:0] btag,
        input logic [VAL_W-1:0] bval
    );
        rs_entry_t r;
        r = e;
        for (int k = 1; k <= 2; k++) begin
            if (e.valid && bvalid && (e.tag[k] != TAG_NONE) && (e.tag[k] == btag)) begin
                r.tag[k] = TAG_NONE;
                r.val[k] = bval;
            end
        end
        return r;
    endfunction

    // in_ready depends only on registered occupancy, so a full station stays
    // closed even in a cycle where an issue frees a slot.
    assign in_ready = (r_count < CNT_W'(DEPTH));
    assign count    = r_count;
    assign w_accept = in_valid && (in_ex_unit == UNIT_ID) && in_ready;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ready[i] = rs_is_ready(r_ent[i]);
        end
    end

    rs_select #(
        .DEPTH (DEPTH)
    ) u_select (
        .i_req    (w_ready),
        .o_onehot (w_sel_onehot),
        .o_idx    (w_sel_idx),
        .o_any    (w_sel_any)
    );

    assign iss_valid = w_sel_any;
    assign w_issue   = w_sel_any && iss_ready;

    // Issue fields are zero whenever nothing is selected.
    always_comb begin
        iss_op     = '0;
        iss_val1   = '0;
        iss_val2   = '0;
        iss_target = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_onehot[i]) begin
                iss_op     = r_ent[i].op;
                iss_val1   = r_ent[i].val[1];
                iss_val2   = r_ent[i].val[2];
                iss_target = r_ent[i].target;
            end
        end
    end

    // Entry array extended by one empty slot so the top entry can shift in
    // "nothing" when the queue collapses.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_ext[i] = r_ent[i];
        end
        w_ext[DEPTH] = '0;
    end

    always_comb begin
        w_new_raw.valid  = 1'b1;
        w_new_raw.op     = in_op;
        w_new_raw.tag[1] = in_tag1;
        w_new_raw.tag[2] = in_tag2;
        w_new_raw.val[1] = in_val1;
        w_new_raw.val[2] = in_val2;
        w_new_raw.target = in_target;
    end

    assign w_new = cdb_capture(w_new_raw, cdb_valid, cdb_tag, cdb_val);

    // Collapse above the issued slot, apply wakeup to the shifted view, then
    // append the new entry right after the survivors.
    always_comb begin
        w_wr_pos = r_count - CNT_W'(w_issue);
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && (IDX_W'(i) >= w_sel_idx)) begin
                w_next[i] = cdb_capture(w_ext[i+1], cdb_valid, cdb_tag, cdb_val);
            end else begin
                w_next[i] = cdb_capture(w_ext[i], cdb_valid, cdb_tag, cdb_val);
            end
            if (w_accept && (CNT_W'(i) == w_wr_pos)) begin
                w_next[i] = w_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else if (flush) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_issue);
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_next[i];
            end
        end
    end

endmodule

// File: tb/tb_ex_rs.sv
// ---------------------------------------------------------------------------
// tb_ex_rs
// Bench for ex_rs: directed scenarios with literal expectations followed by
// randomized traffic, all checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_ex_rs;

    localparam int         DEPTH = 4;
    localparam logic [2:0] UNIT  = 3'd0;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_ex_unit;
    logic [7:0]  in_op;
    logic [4:0]  in_tag1, in_tag2, in_target;
    logic [31:0] in_val1, in_val2;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic        iss_valid, iss_ready;
    logic [7:0]  iss_op;
    logic [31:0] iss_val1, iss_val2;
    logic [4:0]  iss_target;
    logic [2:0]  count;

    always #5 clk = ~clk;

    ex_rs #(
        .DEPTH   (DEPTH),
        .UNIT_ID (UNIT),
        .OP_W    (8),
        .TAG_W   (5),
        .VAL_W   (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ex_unit (in_ex_unit),
        .in_op      (in_op),
        .in_tag1    (in_tag1),
        .in_tag2    (in_tag2),
        .in_val1    (in_val1),
        .in_val2    (in_val2),
        .in_target  (in_target),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_val    (cdb_val),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_op     (iss_op),
        .iss_val1   (iss_val1),
        .iss_val2   (iss_val2),
        .iss_target (iss_target),
        .count      (count)
    );

    // Reference model: list of held instructions, oldest first.
    typedef struct {
        logic [7:0]  op;
        logic [4:0]  t1, t2, target;
        logic [31:0] v1, v2;
    } ment_t;

    ment_t mq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int m_sel();
        int s;
        s = -1;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].t1 == 5'd0 && mq[i].t2 == 5'd0) s = i;
        end
        return s;
    endfunction

    // Next model state from the inputs currently driven.
    task automatic model_next();
        int    s;
        bit    acc;
        ment_t e;
        if (!rst || flush) begin
            mq.delete();
            return;
        end
        acc = in_valid && (in_ex_unit == UNIT) && (mq.size() < DEPTH);
        s   = m_sel();
        if (s >= 0 && iss_ready) mq.delete(s);
        for (int i = 0; i < mq.size(); i++) begin
            e = mq[i];
            if (cdb_valid && e.t1 != 5'd0 && e.t1 == cdb_tag) begin e.v1 = cdb_val; e.t1 = 5'd0; end
            if (cdb_valid && e.t2 != 5'd0 && e.t2 == cdb_tag) begin e.v2 = cdb_val; e.t2 = 5'd0; end
            mq[i] = e;
        end
        if (acc) begin
            e.op = in_op; e.target = in_target;
            e.t1 = in_tag1; e.v1 = in_val1;
            e.t2 = in_tag2; e.v2 = in_val2;
            if (cdb_valid && e.t1 != 5'd0 && e.t1 == cdb_tag) begin e.v1 = cdb_val; e.t1 = 5'd0; end
            if (cdb_valid && e.t2 != 5'd0 && e.t2 == cdb_tag) begin e.v2 = cdb_val; e.t2 = 5'd0; end
            mq.push_back(e);
        end
    endtask

    task automatic compare_all();
        int s;
        s = m_sel();
        chk("count", 64'(count), 64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        chk("iss_valid", 64'(iss_valid), 64'(s >= 0));
        if (s >= 0) begin
            chk("iss_op", 64'(iss_op), 64'(mq[s].op));
            chk("iss_val1", 64'(iss_val1), 64'(mq[s].v1));
            chk("iss_val2", 64'(iss_val2), 64'(mq[s].v2));
            chk("iss_target", 64'(iss_target), 64'(mq[s].target));
        end else begin
            chk("iss_data_zero", {iss_op, iss_val1, iss_val2, iss_target} == '0 ? 64'd0 : 64'd1, 64'd0);
        end
    endtask

    // Inputs are held from one negedge to the next; outputs are checked on the
    // negedge following each rising edge.
    task automatic step();
        model_next();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        in_valid = 1'b0; in_ex_unit = UNIT; in_op = '0;
        in_tag1 = '0; in_tag2 = '0; in_val1 = '0; in_val2 = '0; in_target = '0;
        cdb_valid = 1'b0; cdb_tag = 5'd1; cdb_val = '0;
        flush = 1'b0; iss_ready = 1'b0;
    endtask

    task automatic set_disp(input logic [7:0] op, input logic [4:0] t1, input logic [4:0] t2,
                            input logic [31:0] v1, input logic [31:0] v2, input logic [4:0] tgt);
        in_valid = 1'b1; in_ex_unit = UNIT; in_op = op;
        in_tag1 = t1; in_tag2 = t2; in_val1 = v1; in_val2 = v2; in_target = tgt;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        mq.delete();
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_iss_valid", 64'(iss_valid), 64'd0);
        rst = 1'b1;
        step();

        // Asynchronous reset with three entries held.
        for (int k = 0; k < 3; k++) begin
            set_disp(8'(8'h21 + k), 5'd0, 5'd0, 32'(k), 32'(k + 1), 5'(k + 1));
            step();
        end
        idle();
        chk("t1_held", 64'(count), 64'd3);
        #2 rst = 1'b0;
        mq.delete();
        #1;
        chk("t1_async_count", 64'(count), 64'd0);
        chk("t1_async_iss_valid", 64'(iss_valid), 64'd0);
        chk("t1_async_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("t1_after_release", 64'(count), 64'd0);

        // Another unit's dispatch is ignored; then a ready dispatch issues.
        set_disp(8'h99, 5'd0, 5'd0, 32'd1, 32'd2, 5'd4);
        in_ex_unit = 3'd2;
        step();
        chk("t2_other_unit", 64'(count), 64'd0);
        set_disp(8'h11, 5'd0, 5'd0, 32'd5, 32'd7, 5'd3);
        iss_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("t2_iss_valid", 64'(iss_valid), 64'd1);
        chk("t2_iss_op", 64'(iss_op), 64'h11);
        chk("t2_iss_val1", 64'(iss_val1), 64'd5);
        chk("t2_iss_val2", 64'(iss_val2), 64'd7);
        chk("t2_iss_target", 64'(iss_target), 64'd3);
        step();
        chk("t2_drained", 64'(count), 64'd0);

        // Wakeup two cycles after dispatch.
        idle();
        iss_ready = 1'b1;
        set_disp(8'h33, 5'd4, 5'd0, 32'd0, 32'd9, 5'd5);
        step();
        in_valid = 1'b0;
        chk("t3_waiting", 64'(iss_valid), 64'd0);
        step();
        cdb_valid = 1'b1; cdb_tag = 5'd4; cdb_val = 32'hAB;
        step();
        cdb_valid = 1'b0;
        chk("t3_woken_valid", 64'(iss_valid), 64'd1);
        chk("t3_woken_val1", 64'(iss_val1), 64'hAB);
        chk("t3_woken_val2", 64'(iss_val2), 64'd9);
        step();
        chk("t3_drained", 64'(count), 64'd0);

        // Same-cycle bypass at dispatch.
        idle();
        set_disp(8'h44, 5'd0, 5'd6, 32'h12, 32'd0, 5'd7);
        cdb_valid = 1'b1; cdb_tag = 5'd6; cdb_val = 32'h55;
        step();
        idle();
        chk("t4_bypass_valid", 64'(iss_valid), 64'd1);
        chk("t4_bypass_val2", 64'(iss_val2), 64'h55);
        chk("t4_bypass_val1", 64'(iss_val1), 64'h12);
        iss_ready = 1'b1;
        step();
        chk("t4_drained", 64'(count), 64'd0);

        // Fill, refuse when full, then drain oldest-first.
        idle();
        for (int k = 0; k < 4; k++) begin
            set_disp(8'(8'hA0 + k), 5'd0, 5'd0, 32'(k), 32'(k + 16), 5'(k + 8));
            step();
        end
        chk("t5_full_count", 64'(count), 64'd4);
        chk("t5_full_ready", 64'(in_ready), 64'd0);
        set_disp(8'hEE, 5'd0, 5'd0, 32'd1, 32'd1, 5'd1);
        step();
        in_valid = 1'b0;
        chk("t5_ignored", 64'(count), 64'd4);
        chk("t5_head", 64'(iss_op), 64'hA0);
        iss_ready = 1'b1;
        step();
        chk("t5_ready_after_A", 64'(in_ready), 64'd1);
        chk("t5_order_1", 64'(iss_op), 64'hA1);
        for (int k = 2; k < 4; k++) begin
            step();
            chk("t5_order", 64'(iss_op), 64'(8'hA0 + k));
        end
        step();
        chk("t5_drained", 64'(count), 64'd0);

        // Flush overrides dispatch, issue and wakeup.
        idle();
        for (int k = 0; k < 3; k++) begin
            set_disp(8'(8'h60 + k), 5'd9, 5'd0, 32'd0, 32'd3, 5'(k));
            step();
        end
        set_disp(8'h66, 5'd0, 5'd0, 32'd1, 32'd2, 5'd3);
        iss_ready = 1'b1; flush = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_val = 32'h77;
        step();
        idle();
        chk("t6_flush_count", 64'(count), 64'd0);
        chk("t6_flush_iss_valid", 64'(iss_valid), 64'd0);
        step();
        chk("t6_stays_empty", 64'(count), 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            in_valid   = ($urandom_range(0, 9) < 6);
            in_ex_unit = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : UNIT;
            in_op      = 8'($urandom);
            in_tag1    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            in_tag2    = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            in_val1    = $urandom;
            in_val2    = $urandom;
            in_target  = 5'($urandom);
            cdb_valid  = 1'($urandom_range(0, 1));
            cdb_tag    = 5'($urandom_range(1, 7));
            cdb_val    = $urandom;
            iss_ready  = ($urandom_range(0, 9) < 6);
            flush      = ($urandom_range(0, 99) < 2);
            step();
        end
        idle();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
